ethernet_rx_mac_filter: RTL and testbench
=========================================

# ethernet_rx_mac_filter

Destination-address filter on the receive path, between the MAC's RX AXI-Stream output and the controller's packet receiver. It holds the first beats of each frame until the 6-byte destination MAC address is known. Frames addressed to this station, to broadcast, or (optionally) to multicast are forwarded unchanged. All other frames, and runt frames, are consumed and discarded, and a saturating drop counter is incremented.

## Interface
Parameters:
- data_width_p, 32: AXIS data width; legal values are 32 or 64.
- header_beats_lp (localparam), (48+data_width_p-1)/data_width_p: beats that carry the destination address; 2 at width 32, 1 at width 64.

Ports:
- clk_i  in  1  system clock; the only clock.
- reset_i  in  1  synchronous, active-high reset.
- mac_addr_i  in  48  station address; [47:40] is the first octet on the wire.
- promisc_i  in  1  forward every non-runt frame.
- multicast_en_i  in  1  forward frames whose first destination octet has bit 0 set.
- s_axis_tdata_i  in  data_width_p  RX data from the MAC; byte 0 is [7:0] and is first on the wire.
- s_axis_tkeep_i  in  data_width_p/8  byte enables.
- s_axis_tvalid_i  in  1  input beat valid.
- s_axis_tready_o  out  1  input beat accepted.
- s_axis_tlast_i  in  1  last beat of the frame.
- s_axis_tuser_i  in  1  MAC error flag; meaningful on the last beat.
- m_axis_tdata_o  out  data_width_p  to the receiver.
- m_axis_tkeep_o  out  data_width_p/8  byte enables to the receiver.
- m_axis_tvalid_o  out  1  output beat valid.
- m_axis_tready_i  in  1  receiver can accept.
- m_axis_tlast_o  out  1  last beat of the frame.
- m_axis_tuser_o  out  1  error flag to the receiver.
- drop_count_o  out  16  count of dropped frames; saturates at 16'hFFFF.

## Operation
- Destination octet i is byte i of the frame.
  - Width 32: octets 0-3 are in beat 0; octets 4-5 are in beat 1, bytes 0-1.
  - Width 64: all six octets are in beat 0.
- Match condition (config is sampled in the decision cycle), true if any of:
  - promisc_i;
  - dest == 48'hFFFF_FFFF_FFFF;
  - multicast_en_i & octet0[0];
  - dest == mac_addr_i.
- The FSM has four states:
  - HDR
    - s_axis_tready_o=1 and m_axis_tvalid_o=0.
    - Each accepted beat is stored in hdr_buf[idx] and idx increments.
    - Any accepted beat with tlast while idx<header_beats_lp is a runt: drop_count increments, idx is cleared, the FSM stays in HDR.
    - On the accepted beat with idx==header_beats_lp-1 and no tlast, the decision is taken: match goes to FLUSH, mismatch goes to DROP and drop_count increments.
    - Buffered beats carry only tdata. A buffered beat is never last and its tuser is 0, because a tlast on a header beat takes the runt path.
  - FLUSH
    - s_axis_tready_o=0.
    - Outputs hdr_buf[fidx] registered, with tkeep all ones, tlast=0 and tuser=0.
    - fidx advances on m_axis_tvalid_o & m_axis_tready_i.
    - After the last buffered beat is accepted, the FSM goes to PASS.
  - PASS
    - Combinational pass-through: the m_axis outputs are the s_axis inputs, and s_axis_tready_o=m_axis_tready_i.
    - tkeep, tlast and tuser are forwarded unmodified.
    - An accepted beat with tlast returns the FSM to HDR.
  - DROP
    - s_axis_tready_o=1 and m_axis_tvalid_o=0.
    - An accepted beat with tlast returns the FSM to HDR.
- drop_count_o increments at most once per frame. At 16'hFFFF it holds.
- Frames with tuser=1 are not filtered on error. tuser is passed through to the receiver.

## Timing
- Reset values:
  - State HDR; idx=0, fidx=0.
  - drop_count_o=0, m_axis_tvalid_o=0, s_axis_tready_o=1.
  - m_axis_tlast_o=0, m_axis_tuser_o=0.
- Reset mid-frame returns to HDR immediately. Any remaining beats of that frame are parsed as a new frame. The MAC is reset together with this block, so this case does not arise in the integrated design.
- Decision latency: the first FLUSH beat is valid in the cycle after the last header beat is accepted.
- Added bubble per forwarded frame: header_beats_lp cycles, which is the time spent refilling through FLUSH.
- AXIS rules on the output:
  - Once m_axis_tvalid_o is asserted, it and its data stay stable until m_axis_tready_i.
  - In FLUSH and PASS the block never deasserts valid without a handshake.
- drop_count_o updates in the cycle after the decision or runt beat.
- Back-to-back frames:
  - A beat accepted in HDR directly after a tlast in PASS or DROP is header beat 0 of the next frame.
  - No idle cycle is required between frames.

## Test plan
- Width 32, mac_addr_i=48'h0A1B_2C3D_4E5F, 64-byte frame with dest 0A:1B:2C:3D:4E:5F -> all 16 beats appear on m_axis unchanged, tlast on beat 15, drop_count_o=0.
- Same frame with dest 0A:1B:2C:3D:4E:50 and promisc_i=0 -> no m_axis_tvalid_o, all input beats accepted, drop_count_o=1; with promisc_i=1 the frame is forwarded.
- Broadcast FF:FF:FF:FF:FF:FF, then multicast 01:00:5E:00:00:01 with multicast_en_i=0, then the same multicast with multicast_en_i=1 -> forwarded, dropped, forwarded; drop_count_o=1.
- Runt: 1-beat frame with tlast -> dropped, drop_count_o=1, next 64-byte matching frame forwarded intact.
- Random m_axis_tready_i (50%) and s_axis_tvalid_i gaps over 200 mixed frames -> output equals the golden filtered stream beat-for-beat, tuser=1 frames are preserved, data is stable under backpressure.
- Preload drop_count to 16'hFFFE through 2 mismatches after 65534 drops (or force) -> saturates at 16'hFFFF; reset asserted in PASS -> drop_count_o=0, state HDR.

Source files
------------

// File: rtl/ethernet_rx_mac_filter.sv
// Receive-path destination-address filter: holds the header beats until the
// destination MAC is known, then forwards or silently drops the frame.
module ethernet_rx_mac_filter #(
  parameter int data_width_p = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [47:0]               mac_addr_i,
  input  logic                      promisc_i,
  input  logic                      multicast_en_i,
  input  logic [data_width_p-1:0]   s_axis_tdata_i,
  input  logic [data_width_p/8-1:0] s_axis_tkeep_i,
  input  logic                      s_axis_tvalid_i,
  output logic                      s_axis_tready_o,
  input  logic                      s_axis_tlast_i,
  input  logic                      s_axis_tuser_i,
  output logic [data_width_p-1:0]   m_axis_tdata_o,
  output logic [data_width_p/8-1:0] m_axis_tkeep_o,
  output logic                      m_axis_tvalid_o,
  input  logic                      m_axis_tready_i,
  output logic                      m_axis_tlast_o,
  output logic                      m_axis_tuser_o,
  output logic [15:0]               drop_count_o
);

  localparam int header_beats_lp = (48 + data_width_p - 1) / data_width_p;
  localparam int idx_w_lp        = (header_beats_lp > 1) ? $clog2(header_beats_lp) : 1;

  typedef enum logic [1:0] {HDR, FLUSH, PASS, DROP} state_e;

  state_e                r_state;
  logic [data_width_p-1:0] r_hdr_buf [header_beats_lp];
  logic [idx_w_lp-1:0]   r_idx;
  logic [idx_w_lp-1:0]   r_fidx;
  logic [15:0]           r_drop_count;

  logic [header_beats_lp*data_width_p-1:0] w_hdr_flat;
  logic [47:0] w_dest;
  logic        w_match;
  logic        w_last_hdr;
  logic        w_drop_inc;

  // The final header beat is still on the input bus when the decision is made.
  always_comb begin
    w_hdr_flat = '0;
    w_dest     = '0;
    for (int unsigned b = 0; b < header_beats_lp; b++) begin
      if (b == header_beats_lp - 1) w_hdr_flat[b*data_width_p +: data_width_p] = s_axis_tdata_i;
      else                          w_hdr_flat[b*data_width_p +: data_width_p] = r_hdr_buf[b];
    end
    for (int unsigned o = 0; o < 6; o++) begin
      w_dest[47-8*o -: 8] = w_hdr_flat[8*o +: 8];
    end
  end

  assign w_match    = promisc_i | (&w_dest) | (multicast_en_i & w_dest[40]) | (w_dest == mac_addr_i);
  assign w_last_hdr = (r_idx == idx_w_lp'(header_beats_lp - 1));
  assign w_drop_inc = (r_state == HDR) & s_axis_tvalid_i &
                      (s_axis_tlast_i | (w_last_hdr & ~w_match));

  always_comb begin
    s_axis_tready_o = 1'b1;
    m_axis_tvalid_o = 1'b0;
    m_axis_tdata_o  = '0;
    m_axis_tkeep_o  = '0;
    m_axis_tlast_o  = 1'b0;
    m_axis_tuser_o  = 1'b0;
    case (r_state)
      FLUSH: begin
        s_axis_tready_o = 1'b0;
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = r_hdr_buf[r_fidx];
        m_axis_tkeep_o  = '1;
      end
      PASS: begin
        s_axis_tready_o = m_axis_tready_i;
        m_axis_tvalid_o = s_axis_tvalid_i;
        m_axis_tdata_o  = s_axis_tdata_i;
        m_axis_tkeep_o  = s_axis_tkeep_i;
        m_axis_tlast_o  = s_axis_tlast_i;
        m_axis_tuser_o  = s_axis_tuser_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= HDR;
      r_idx        <= '0;
      r_fidx       <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_drop_inc && (r_drop_count != '1)) r_drop_count <= r_drop_count + 16'd1;
      case (r_state)
        HDR: if (s_axis_tvalid_i) begin
          r_hdr_buf[r_idx] <= s_axis_tdata_i;
          if (s_axis_tlast_i) begin
            r_idx <= '0;
          end else if (w_last_hdr) begin
            r_idx   <= '0;
            r_state <= w_match ? FLUSH : DROP;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        FLUSH: if (m_axis_tready_i) begin
          if (r_fidx == idx_w_lp'(header_beats_lp - 1)) begin
            r_fidx  <= '0;
            r_state <= PASS;
          end else begin
            r_fidx <= r_fidx + 1'b1;
          end
        end
        PASS: if (s_axis_tvalid_i && m_axis_tready_i && s_axis_tlast_i) r_state <= HDR;
        DROP: if (s_axis_tvalid_i && s_axis_tlast_i) r_state <= HDR;
        default: r_state <= HDR;
      endcase
    end
  end

  assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_ethernet_rx_mac_filter.sv
// Bench for ethernet_rx_mac_filter: directed plus random frames compared
// against a frame-level forwarding model.
module tb_ethernet_rx_mac_filter;

  localparam int W = 32;
  localparam int HDR_BEATS = (48 + W - 1) / W;
  localparam logic [47:0] STATION = 48'h0A1B_2C3D_4E5F;

  typedef struct {
    logic [W-1:0]   d;
    logic [W/8-1:0] k;
    logic           l;
    logic           u;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_i = 1'b1;
  logic [47:0]    mac_addr_i = STATION;
  logic           promisc_i = 1'b0;
  logic           multicast_en_i = 1'b0;
  logic [W-1:0]   s_tdata = '0;
  logic [W/8-1:0] s_tkeep = '0;
  logic           s_tvalid = 1'b0;
  logic           s_tready;
  logic           s_tlast = 1'b0;
  logic           s_tuser = 1'b0;
  logic [W-1:0]   m_tdata;
  logic [W/8-1:0] m_tkeep;
  logic           m_tvalid;
  logic           m_tready = 1'b1;
  logic           m_tlast;
  logic           m_tuser;
  logic [15:0]    drop_count;

  ethernet_rx_mac_filter #(.data_width_p(W)) dut (
    .clk_i(clk), .reset_i(reset_i), .mac_addr_i(mac_addr_i),
    .promisc_i(promisc_i), .multicast_en_i(multicast_en_i),
    .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tvalid_i(s_tvalid),
    .s_axis_tready_o(s_tready), .s_axis_tlast_i(s_tlast), .s_axis_tuser_i(s_tuser),
    .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep), .m_axis_tvalid_o(m_tvalid),
    .m_axis_tready_i(m_tready), .m_axis_tlast_o(m_tlast), .m_axis_tuser_o(m_tuser),
    .drop_count_o(drop_count)
  );

  beat_t exp_q[$];
  beat_t frm[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    exp_drops = 0;
  int    fwd_beats = 0;
  bit    mon_en = 1'b0;
  bit    rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) m_tready = ($urandom_range(0, 1) == 1);
  end

  // Output monitor: scoreboard pop on each handshake, stability while stalled.
  initial begin
    bit    hold;
    beat_t held;
    beat_t e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        hold = 1'b0;
      end else begin
        if (hold)
          check("stable_under_stall", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser},
                {1'b1, held.d, held.k, held.l, held.u});
        if (m_tvalid && m_tready) begin
          fwd_beats++;
          check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, {e.d, e.k, e.l, e.u});
          end
        end
        hold   = m_tvalid && !m_tready;
        held.d = m_tdata; held.k = m_tkeep; held.l = m_tlast; held.u = m_tuser;
      end
    end
  end

  function automatic bit model_fwd(input logic [47:0] dest, input int nbeats);
    if (nbeats <= HDR_BEATS) return 1'b0;
    return promisc_i || (dest == 48'hFFFF_FFFF_FFFF) || (multicast_en_i && dest[40]) ||
           (dest == mac_addr_i);
  endfunction

  // Octet i of the destination is byte i of the frame, first on the wire.
  task automatic build_frame(input logic [47:0] dest, input int nbeats, input bit user,
                             input logic [3:0] lastkeep);
    beat_t x;
    frm.delete();
    for (int b = 0; b < nbeats; b++) begin
      x.d = $urandom;
      if (b == 0) x.d = {dest[23:16], dest[31:24], dest[39:32], dest[47:40]};
      if (b == 1) x.d[15:0] = {dest[7:0], dest[15:8]};
      x.l = (b == nbeats - 1);
      x.k = x.l ? lastkeep : 4'hF;
      x.u = x.l ? user : 1'b0;
      frm.push_back(x);
    end
  endtask

  task automatic drive_beat(input beat_t x, input bit gaps);
    bit acc;
    int n;
    s_tdata = x.d; s_tkeep = x.k; s_tlast = x.l; s_tuser = x.u; s_tvalid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
    s_tvalid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [47:0] dest, input int nbeats, input bit user,
                            input logic [3:0] lastkeep, input bit gaps);
    build_frame(dest, nbeats, user, lastkeep);
    if (model_fwd(dest, nbeats)) foreach (frm[i]) exp_q.push_back(frm[i]);
    else if (exp_drops < 65535) exp_drops++;
    foreach (frm[i]) drive_beat(frm[i], gaps);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_drop_count"}, 64'(drop_count), 64'(exp_drops));
  endtask

  initial begin
    int          base;
    logic [47:0] dest;
    logic [3:0]  keeps [4];
    keeps[0] = 4'h1; keeps[1] = 4'h3; keeps[2] = 4'h7; keeps[3] = 4'hF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd1);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_m_tuser", 64'(m_tuser), 64'd0);
    reset_i = 1'b0;
    mon_en  = 1'b1;

    base = fwd_beats;
    send_frame(STATION, 16, 1'b0, 4'hF, 1'b0);
    drain("own_addr");
    check("own_addr_beats", 64'(fwd_beats - base), 64'd16);

    send_frame(48'h0A1B_2C3D_4E50, 16, 1'b0, 4'hF, 1'b0);
    drain("mismatch");
    promisc_i = 1'b1;
    send_frame(48'h0A1B_2C3D_4E50, 16, 1'b0, 4'hF, 1'b0);
    drain("promisc");
    promisc_i = 1'b0;

    send_frame(48'hFFFF_FFFF_FFFF, 16, 1'b0, 4'hF, 1'b0);
    drain("broadcast");
    send_frame(48'h0100_5E00_0001, 16, 1'b0, 4'hF, 1'b0);
    drain("mcast_off");
    multicast_en_i = 1'b1;
    send_frame(48'h0100_5E00_0001, 16, 1'b0, 4'hF, 1'b0);
    drain("mcast_on");
    multicast_en_i = 1'b0;

    send_frame(STATION, 1, 1'b0, 4'hF, 1'b0);
    send_frame(STATION, 16, 1'b1, 4'h3, 1'b0);
    drain("runt_then_frame");

    rnd_ready = 1'b1;
    for (int f = 0; f < 200; f++) begin
      case ($urandom_range(0, 4))
        0: dest = STATION;
        1: dest = 48'hFFFF_FFFF_FFFF;
        2: dest = {8'($urandom | 1), 8'($urandom), 32'($urandom)};
        3: dest = STATION ^ (48'd1 << $urandom_range(0, 47));
        default: dest = {8'($urandom & 8'hFE), 8'($urandom), 32'($urandom)};
      endcase
      promisc_i      = ($urandom_range(0, 7) == 0);
      multicast_en_i = ($urandom_range(0, 1) == 1);
      send_frame(dest, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 12),
                 ($urandom_range(0, 3) == 0), keeps[$urandom_range(0, 3)], 1'b1);
    end
    drain("random");
    rnd_ready = 1'b0;
    m_tready = 1'b1;
    promisc_i = 1'b0;
    multicast_en_i = 1'b0;

    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    exp_drops = 0;
    check("sat_cleared", 64'(drop_count), 64'd0);
    // One runt per cycle while tvalid/tlast are held high.
    s_tdata = $urandom; s_tkeep = 4'hF; s_tlast = 1'b1; s_tuser = 1'b0; s_tvalid = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    exp_drops = 65534;
    repeat (2) @(posedge clk);
    #1;
    check("sat_fffe", 64'(drop_count), 64'hFFFE);
    send_frame(48'h0A1B_2C3D_4E50, 4, 1'b0, 4'hF, 1'b0);
    drain("sat_first");
    send_frame(48'h0A1B_2C3D_4E50, 4, 1'b0, 4'hF, 1'b0);
    drain("sat_hold");

    mon_en = 1'b0;
    build_frame(STATION, 16, 1'b0, 4'hF);
    for (int b = 0; b < 4; b++) drive_beat(frm[b], 1'b0);
    m_tready = 1'b0;
    #1;
    check("pass_ready_follows", 64'(s_tready), 64'd0);
    reset_i = 1'b1;
    @(posedge clk); #1;
    check("rst_pass_drop_count", 64'(drop_count), 64'd0);
    check("rst_pass_s_tready", 64'(s_tready), 64'd1);
    check("rst_pass_m_tvalid", 64'(m_tvalid), 64'd0);
    reset_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
